div_seq_16x8_2sc: RTL and testbench

//   Sequential two's-complement divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient + 8-bit remainder.

---
 rtl/div_seq_16x8_2sc.sv | 159 +++++++++++++++
 tb/tb_div_seq_16x8_2sc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_16x8_2sc.sv
// Sequential two's-complement divider (2N-bit dividend / N-bit divisor).
// Restoring division on magnitudes, one quotient bit per clock, then a sign fix-up cycle.
module div_seq_16x8_2sc #(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           start_i,
  input  logic [2*N-1:0] a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [N-1:0]   q_o,
  output logic [N-1:0]   r_o,
  output logic           ovf_o,
  output logic           dz_o
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0]  LAST_STEP = CW'(2*N-1);
  localparam logic [2*N-1:0] MAX_POS   = (2*N)'((1 << (N-1)) - 1);
  localparam logic [2*N-1:0] MAX_NEG   = (2*N)'(1 << (N-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state_q;
  logic [2*N-1:0] aMag_q;
  logic [N-1:0]   bMag_q;
  logic [N:0]     rem_q;
  logic [2*N-1:0] quo_q;
  logic [CW-1:0]  cnt_q;
  logic           signQ_q;
  logic           signR_q;
  logic           dzInt_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   r_q;
  logic           ovf_q;
  logic           dz_q;

  logic [2*N-1:0] aMag_d;
  logic [N-1:0]   bMag_d;
  logic [N:0]     remShift;
  logic [N:0]     remDiff;
  logic           remGe;
  logic [N:0]     rem_d;
  logic [2*N-1:0] quo_d;
  logic           ovf_d;
  logic [N-1:0]   qFix_d;
  logic [N-1:0]   rFix_d;

  // Operand magnitudes; the most negative values map onto their full-width magnitude.
  always_comb begin
    aMag_d = a_i[2*N-1] ? -a_i : a_i;
    bMag_d = b_i[N-1]   ? -b_i : b_i;
  end

  // One restoring step: shift in the next dividend bit and subtract when it fits.
  always_comb begin
    remShift = {rem_q[N-1:0], aMag_q[2*N-1]};
    remDiff  = remShift - {1'b0, bMag_q};
    remGe    = (remShift >= {1'b0, bMag_q});
    rem_d    = remGe ? remDiff : remShift;
    quo_d    = {quo_q[2*N-2:0], remGe};
  end

  // Sign fix-up; negating zero yields zero, so no negative zero can appear.
  always_comb begin
    ovf_d  = (!signQ_q && (quo_q > MAX_POS)) || (signQ_q && (quo_q > MAX_NEG));
    qFix_d = signQ_q ? -quo_q[N-1:0] : quo_q[N-1:0];
    rFix_d = signR_q ? -rem_q[N-1:0] : rem_q[N-1:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      aMag_q  <= '0;
      bMag_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      signQ_q <= 1'b0;
      signR_q <= 1'b0;
      dzInt_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            aMag_q  <= aMag_d;
            bMag_q  <= bMag_d;
            signQ_q <= a_i[2*N-1] ^ b_i[N-1];
            signR_q <= a_i[2*N-1];
            dzInt_q <= (b_i == '0);
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          aMag_q <= {aMag_q[2*N-2:0], 1'b0};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (dzInt_q) begin
            q_q   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b1;
          end else if (ovf_d) begin
            q_q   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b1;
            dz_q  <= 1'b0;
          end else begin
            q_q   <= qFix_d;
            r_q   <= rFix_d;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o    = q_q;
  assign r_o    = r_q;
  assign ovf_o  = ovf_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_div_seq_16x8_2sc.sv
// Self-checking bench for div_seq_16x8_2sc: vector table plus handshake, held-start and reset-abort sequences.
module tb_div_seq_16x8_2sc;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } vec_t;

  logic        clk_i;
  logic        reset_ni;
  logic        start_i;
  logic [15:0] a_i;
  logic [7:0]  b_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  q_o;
  logic [7:0]  r_o;
  logic        ovf_o;
  logic        dz_o;

  int nChecks = 0;
  int nFail   = 0;

  vec_t vecs[17];

  div_seq_16x8_2sc #(.N(8)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .q_o      (q_o),
    .r_o      (r_o),
    .ovf_o    (ovf_o),
    .dz_o     (dz_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Launches one operation and returns the number of edges after E0 until done.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, output int lat);
    @(negedge clk_i);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a_i     = 16'h0;
    b_i     = 8'h0;
    checkOutput("busy_after_start", {15'b0, busy_o}, 16'd1);
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int lat;
    string tag;
    applyStimulus(v.a, v.b, lat);
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, "_latency"}, 16'(lat), 16'd17);
    checkOutput({tag, "_q"}, {8'h0, q_o}, {8'h0, v.q});
    checkOutput({tag, "_r"}, {8'h0, r_o}, {8'h0, v.r});
    checkOutput({tag, "_ovf"}, {15'b0, ovf_o}, {15'b0, v.ovf});
    checkOutput({tag, "_dz"}, {15'b0, dz_o}, {15'b0, v.dz});
    checkOutput({tag, "_busy_at_done"}, {15'b0, busy_o}, 16'd0);
    tick();
    checkOutput({tag, "_done_pulse"}, {15'b0, done_o}, 16'd0);
    checkOutput({tag, "_q_hold"}, {8'h0, q_o}, {8'h0, v.q});
  endtask

  initial begin
    int lat;
    int doneCount;

    vecs[0]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h3F01, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{16'h3F80, 8'h7F, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{16'h04D2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{16'h0080, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{16'h007F, 8'hFF, 8'h81, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{16'hFF81, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{16'h03E8, 8'h80, 8'hF9, 8'h68, 1'b0, 1'b0};
    vecs[16] = '{16'h8000, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};

    reset_ni = 1'b0;
    start_i  = 1'b0;
    a_i      = 16'h0;
    b_i      = 8'h0;
    repeat (3) tick();
    checkOutput("reset_busy", {15'b0, busy_o}, 16'd0);
    checkOutput("reset_done", {15'b0, done_o}, 16'd0);
    checkOutput("reset_q", {8'h0, q_o}, 16'h0);
    checkOutput("reset_r", {8'h0, r_o}, 16'h0);
    checkOutput("reset_ovf", {15'b0, ovf_o}, 16'd0);
    checkOutput("reset_dz", {15'b0, dz_o}, 16'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      runVector(vecs[i], i);
    end

    // Start held high with operands changing after capture: the second op uses operands present after done.
    @(negedge clk_i);
    a_i       = 16'h0064;
    b_i       = 8'h07;
    start_i   = 1'b1;
    doneCount = 0;
    for (int k = 0; k <= 36; k++) begin
      tick();
      if (k == 0) begin
        a_i = 16'hFF9C;
        b_i = 8'h7F;
      end
      if (done_o === 1'b1) doneCount++;
      if ((k >= 0 && k <= 16) || (k >= 18 && k <= 34)) begin
        checkOutput($sformatf("held_busy_k%0d", k), {15'b0, busy_o}, 16'd1);
      end
      if (k == 16) checkOutput("held_done_k16", {15'b0, done_o}, 16'd0);
      if (k == 17) begin
        checkOutput("held_done1", {15'b0, done_o}, 16'd1);
        checkOutput("held_q1", {8'h0, q_o}, 16'h000E);
        checkOutput("held_r1", {8'h0, r_o}, 16'h0002);
      end
      if (k == 30) checkOutput("held_q1_hold", {8'h0, q_o}, 16'h000E);
      if (k == 35) begin
        checkOutput("held_done2", {15'b0, done_o}, 16'd1);
        checkOutput("held_q2", {8'h0, q_o}, 16'h0000);
        checkOutput("held_r2", {8'h0, r_o}, 16'h009C);
        start_i = 1'b0;
      end
      if (k == 36) checkOutput("held_idle_after", {15'b0, busy_o}, 16'd0);
    end
    checkOutput("held_done_count", 16'(doneCount), 16'd2);

    // Load nonzero results, then abort an operation with reset in the middle of the division.
    runVector(vecs[0], 100);
    @(negedge clk_i);
    a_i     = 16'hFF9C;
    b_i     = 8'h07;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    @(negedge clk_i);
    reset_ni = 1'b0;
    tick();
    checkOutput("abort_busy", {15'b0, busy_o}, 16'd0);
    checkOutput("abort_done", {15'b0, done_o}, 16'd0);
    checkOutput("abort_q", {8'h0, q_o}, 16'h0);
    checkOutput("abort_r", {8'h0, r_o}, 16'h0);
    checkOutput("abort_ovf", {15'b0, ovf_o}, 16'd0);
    checkOutput("abort_dz", {15'b0, dz_o}, 16'd0);
    @(negedge clk_i);
    reset_ni  = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) doneCount++;
    end
    checkOutput("abort_no_done", 16'(doneCount), 16'd0);
    runVector(vecs[1], 101);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
